// File: rtl/up_down_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// up_down_counter: WIDTH-bit wrapping up/down counter with synchronous reset.
// Revision: 1.0
// ---------------------------------------------------------------------------
module up_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up_down,
  output logic [WIDTH-1:0] counter
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Unsigned WIDTH-bit add/subtract; carry and borrow fall off the top.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
    end else if (up_down) begin
      counter <= counter + ONE;
    end else begin
      counter <= counter - ONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_up_down_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_up_down_counter: directed vectors with a queue-based scoreboard.
// ---------------------------------------------------------------------------
module tb_up_down_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       up_down = 1'b0;
  logic [3:0] counter;

  int total = 0;
  int bad = 0;
  logic [3:0] exp_q[$];
  string      name_q[$];
  logic       stim_done = 1'b0;

  up_down_counter #(.WIDTH(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .up_down(up_down),
    .counter(counter)
  );

  always #50 clk = ~clk;

  // Drive one edge's inputs after a falling edge; optionally glitch up_down
  // mid-cycle and restore it before the rising edge.
  task automatic step(input logic r, input logic u, input logic [3:0] exp,
                      input string nm, input bit glitch = 1'b0);
    @(negedge clk);
    reset   = r;
    up_down = u;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    if (glitch) begin
      #10 up_down = ~u;
      #10 up_down = u;
    end
  endtask

  // Monitor: one expectation corresponds to each issued edge.
  initial begin
    logic [3:0] e;
    string      n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        total++;
        if (counter !== e) begin
          bad++;
          $display("FAIL %s: counter=%0d expected=%0d", n, counter, e);
        end
      end
    end
  end

  initial begin
    // Reset edge then count up.
    step(1'b1, 1'b0, 4'd0, "reset_state");
    step(1'b0, 1'b1, 4'd1, "up_1");
    step(1'b0, 1'b1, 4'd2, "up_2");
    step(1'b0, 1'b1, 4'd3, "up_3");

    // Full up-count with wrap 15 -> 0.
    step(1'b1, 1'b1, 4'd0, "reset_before_wrap");
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1, 4'(i % 16), (i == 16) ? "wrap_up" : "up_seq");
    end

    // Down from 0 wraps to 15.
    step(1'b1, 1'b0, 4'd0, "reset_before_down");
    step(1'b0, 1'b0, 4'd15, "wrap_down");
    step(1'b0, 1'b0, 4'd14, "down_14");
    step(1'b0, 1'b0, 4'd13, "down_13");

    // Reset mid-count at 7 overrides up.
    step(1'b1, 1'b0, 4'd0, "reset_before_7");
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, 1'b1, 4'(i), "up_to_7");
    end
    step(1'b1, 1'b1, 4'd0, "reset_priority");
    step(1'b0, 1'b1, 4'd1, "after_release");

    // Direction toggles from 5 with no dead cycle.
    step(1'b1, 1'b0, 4'd0, "reset_before_5");
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1, 4'(i), "up_to_5");
    end
    step(1'b0, 1'b1, 4'd6, "toggle_up_6");
    step(1'b0, 1'b0, 4'd5, "toggle_down_5");
    step(1'b0, 1'b1, 4'd6, "toggle_up_6b");
    step(1'b0, 1'b0, 4'd5, "toggle_down_5b");

    // Between-edge glitches on up_down must not affect the sampled value.
    step(1'b0, 1'b1, 4'd6, "glitch_up", 1'b1);
    step(1'b0, 1'b0, 4'd5, "glitch_down", 1'b1);
    step(1'b0, 1'b0, 4'd4, "glitch_down_2", 1'b1);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/up_down_counter.md
UP_DOWN_COUNTER -- requirements
Module: up_down_counter

Interface
- REQ-001: Parameter WIDTH, default 4, counter bit width; the SHALL requirements below use WIDTH=4, and any WIDTH>=1 SHALL behave identically modulo 2^WIDTH.
- REQ-002: Port clk, input, 1, sole clock; all state SHALL update only on the rising edge.
- REQ-003: Port reset, input, 1, synchronous active-high reset, sampled only on the rising edge of clk.
- REQ-004: Port up_down, input, 1, count direction; 1 SHALL mean count up and 0 SHALL mean count down.
- REQ-005: Port counter, output, WIDTH (4), current count value, driven directly from a register.
- REQ-006: The design SHALL have one clock and a synchronous, active-high reset; there SHALL be no other ports.

Function
- REQ-007: On a rising edge of clk with reset=1, counter SHALL become 0 regardless of up_down.
- REQ-008: On a rising edge with reset=0 and up_down=1, counter SHALL become counter+1 modulo 16.
- REQ-009: On a rising edge with reset=0 and up_down=0, counter SHALL become counter-1 modulo 16.
- REQ-010: Counting up SHALL wrap from 15 to 0 with no stall or saturation.
- REQ-011: Counting down SHALL wrap from 0 to 15 with no stall or saturation.
- REQ-012: Latency SHALL be one cycle; the value sampled on up_down at edge N SHALL be reflected on counter immediately after edge N.
- REQ-013: A change of up_down between edges SHALL have no effect until the next rising edge.
- REQ-014: The counter SHALL step exactly once per rising edge while reset=0; there is no enable and no hold state.
- REQ-015: A direction reversal SHALL take effect on the first edge where it is sampled, with no dead cycle (for example 5 up -> 6, then down -> 5).
- REQ-016: counter SHALL be a pure register output with no combinational path from up_down or reset to counter.
- REQ-017: Arithmetic SHALL be unsigned WIDTH-bit; carry and borrow out SHALL be discarded.

Reset
- REQ-018: Reset SHALL take priority over counting when both apply on the same edge.
- REQ-019: Asserting reset mid-count SHALL force counter to 0 on the next rising edge, with no asynchronous clear between edges.
- REQ-020: On the first rising edge after reset deasserts, counter SHALL step from 0 according to up_down (up -> 1, down -> 15).
- REQ-021: Before the first reset edge, counter SHALL be undefined; verification SHALL NOT check it.

Verification
- REQ-022: Clock period 100 units; reset=1 and up_down=0 for the first edge, then reset=0 and up_down=1 -> counter=0 after the reset edge, then 1, 2, 3, ... on successive edges.
- REQ-023: Count up from 0 for 16 edges -> sequence 1..15, then 0 (wrap).
- REQ-024: Starting at 0 after reset, up_down=0 -> counter 15, 14, 13 on successive edges.
- REQ-025: Counter at 7, reset=1 for one edge while up_down=1 -> counter 0; after reset is released -> 1.
- REQ-026: Counter at 5, up_down toggled 1,0,1,0 on successive edges -> counter 6, 5, 6, 5.
- REQ-027: up_down glitched between edges and returned to its prior value before the edge -> counter follows only the sampled value; no extra step occurs.
